cache_tag_lookup: RTL and testbench
===================================

# cache_tag_lookup

Parametrised, registered N-way tag lookup for the set-associative cache controller. Compares an incoming tag against every way of the indexed set and reports hit, hit way, hit MESI state, multi-hit error and a replacement victim. The victim is the first invalid way, otherwise a tree-PLRU pick. It sits between the set-array read port and the MESI/bus-snoop controller, behind a valid/ready handshake on both sides so either side can stall.

## Interface
- WAYS, 8, associativity; power of two, 2..16
- TAG, 12, tag width in bits
- WAY_W, $clog2(WAYS), way-index width (derived, do not override)
- CNT_W, 16, statistics counter width (used only with CACHE_LOOKUP_STATS_EN)

- clk  in  1  single clock, all logic on rising edge
- rstb  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request this cycle
- req_write  in  1  1 = write access, 0 = read access
- tag_in  in  TAG  tag to look up
- set_tags  in  WAYS*TAG  tags of indexed set; way w at [w*TAG +: TAG]
- set_mesi  in  WAYS*2  MESI per way at [w*2 +: 2]; I=00, S=01, E=10, M=11
- set_plru  in  WAYS-1  PLRU tree bits of indexed set, heap order, node 0 = root
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_hit  out  1  tag match on a non-I way
- rsp_read_hit / rsp_write_hit  out  1 each  rsp_hit qualified by access type
- rsp_way  out  WAY_W  hit way (lowest matching index); 0 on miss
- rsp_mesi  out  2  MESI of hit way; I on miss
- rsp_multi_hit  out  1  more than one valid way matched (error)
- rsp_victim  out  WAY_W  replacement way
- rsp_victim_dirty  out  1  victim state is M (writeback needed)

## Operation
- Transfer occurs on req_valid && req_ready. All lookup results are computed combinationally from the request inputs and captured into one output register stage at transfer.
- req_ready = !rsp_valid || rsp_ready. This gives full throughput, one request per cycle, under no backpressure.
- Match vector: way w matches when tag(w) == tag_in and mesi(w) != I. rsp_hit = OR of the vector. rsp_way = lowest set index. rsp_multi_hit = popcount > 1.
- Victim, first rule that applies:
  - lowest-index way with mesi == I;
  - otherwise walk the PLRU tree from node n=0. Bit 0 -> child 2n+1 (lower half); bit 1 -> child 2n+2 (upper half). Continue for log2(WAYS) levels. The leaf gives the way.
- rsp_victim_dirty = victim's mesi == M. Victim is reported on hits too; the consumer ignores it.
- This block does not update PLRU or MESI; it only reports.

## Timing
- Latency: 1 cycle. A request accepted at edge k produces rsp_valid=1 after edge k.
- Response fields stay stable while rsp_valid && !rsp_ready.
- Response capture and a new transfer in the same cycle (rsp_ready=1 with req_valid=1) replace the response seamlessly. rsp_valid stays 1.
- rsp_valid clears after an edge with rsp_ready=1 and no new transfer.
- Reset (rstb=0 at an edge): rsp_valid=0, and all rsp_* = 0 (rsp_mesi=I, way/victim 0). req_ready reads 1 after reset. A pending response is discarded with no partial state. Requests presented during reset are not accepted.
- Request inputs need not be held after transfer.

## Configuration
- CACHE_LOOKUP_STATS_EN defined:
  - adds input stats_clr (1) and outputs hit_cnt, miss_cnt, multi_cnt (CNT_W each);
  - on each request transfer, exactly one of hit_cnt/miss_cnt increments; multi_cnt also increments on multi-hit;
  - counters saturate at all-ones;
  - stats_clr zeroes all three at the edge and wins over a simultaneous increment;
  - reset value 0.
- Not defined: these ports and counters do not exist; lookup behaviour is identical.

## Test plan
- WAYS=8, set_mesi all E, tag(5)=0x3A5, tag_in=0x3A5, read -> next cycle rsp_valid=1, rsp_hit=1, rsp_read_hit=1, rsp_way=5, rsp_mesi=E, rsp_multi_hit=0.
- Same tag in ways 2 and 6, both S -> rsp_way=2, rsp_multi_hit=1. Same tag in way 2 with way-2 mesi=I -> rsp_hit=0, rsp_way=0, rsp_mesi=I.
- Miss, ways 3 and 4 invalid -> rsp_victim=3. All valid, set_plru=0 -> victim 0. Root=1, node2=1, node6=1 -> victim 7; with way 7 = M, rsp_victim_dirty=1.
- Backpressure: rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0, response stable. Then rsp_ready=1 and a back-to-back stream of 4 requests -> 4 responses on 4 consecutive cycles, in order.
- Reset mid-operation: rstb=0 while rsp_valid=1 and rsp_ready=0 -> after the edge rsp_valid=0 and all outputs 0. The first request after reset completes normally.
- STATS_EN, CNT_W=4: 20 hits -> hit_cnt=15 (saturated). stats_clr asserted together with a miss transfer -> miss_cnt=0.

Source files
------------

// File: rtl/cache_tag_lookup.sv
// N-way registered tag lookup: hit/way/MESI/multi-hit plus victim (first invalid, else tree-PLRU).
// Optional hit/miss/multi-hit counters are compiled in with CACHE_LOOKUP_STATS_EN.
module cache_tag_lookup #(
  parameter int unsigned WAYS  = 8,
  parameter int unsigned TAG   = 12,
  parameter int unsigned WAY_W = $clog2(WAYS),
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [TAG-1:0]       tag_in,
  input  logic [WAYS*TAG-1:0]  set_tags,
  input  logic [WAYS*2-1:0]    set_mesi,
  input  logic [WAYS-2:0]      set_plru,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_hit,
  output logic                 rsp_read_hit,
  output logic                 rsp_write_hit,
  output logic [WAY_W-1:0]     rsp_way,
  output logic [1:0]           rsp_mesi,
  output logic                 rsp_multi_hit,
  output logic [WAY_W-1:0]     rsp_victim,
  output logic                 rsp_victim_dirty
`ifdef CACHE_LOOKUP_STATS_EN
  ,
  input  logic                 stats_clr,
  output logic [CNT_W-1:0]     hit_cnt,
  output logic [CNT_W-1:0]     miss_cnt,
  output logic [CNT_W-1:0]     multi_cnt
`endif
);

  localparam int unsigned Lvls  = $clog2(WAYS);
  localparam logic [1:0]  MesiI = 2'b00;
  localparam logic [1:0]  MesiM = 2'b11;

  logic             xfer;
  logic [WAYS-1:0]  match;
  logic             hit_c;
  logic             multi_c;
  logic [WAY_W-1:0] way_c;
  logic [1:0]       mesi_c;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic             plru_dirty;
  logic             path_ok;
  logic [WAY_W-1:0] victim_c;
  logic             dirty_c;

  assign req_ready = !rsp_valid || rsp_ready;
  assign xfer      = req_valid && req_ready;

  always_comb begin
    match      = '0;
    hit_c      = 1'b0;
    multi_c    = 1'b0;
    way_c      = '0;
    mesi_c     = MesiI;
    inv_found  = 1'b0;
    inv_way    = '0;
    plru_way   = '0;
    plru_dirty = 1'b0;
    path_ok    = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      match[w] = (set_tags[w*TAG +: TAG] == tag_in) && (set_mesi[w*2 +: 2] != MesiI);
      if (match[w]) begin
        multi_c = multi_c | hit_c;
        hit_c   = 1'b1;
      end
    end
    // Descending scan so the lowest index is the last one written.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (match[w]) begin
        way_c  = WAY_W'(w);
        mesi_c = set_mesi[w*2 +: 2];
      end
      if (set_mesi[w*2 +: 2] == MesiI) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    // A leaf is the PLRU pick when every tree node on its root path points toward it.
    for (int w = 0; w < int'(WAYS); w++) begin
      path_ok = 1'b1;
      for (int l = 0; l < int'(Lvls); l++) begin
        if (set_plru[(1 << l) - 1 + (w >> (int'(Lvls) - l))] != ((w >> (int'(Lvls) - 1 - l)) & 1))
          path_ok = 1'b0;
      end
      if (path_ok) begin
        plru_way   = WAY_W'(w);
        plru_dirty = (set_mesi[w*2 +: 2] == MesiM);
      end
    end
    victim_c = inv_found ? inv_way : plru_way;
    dirty_c  = inv_found ? 1'b0 : plru_dirty;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      rsp_valid        <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_read_hit     <= 1'b0;
      rsp_write_hit    <= 1'b0;
      rsp_way          <= '0;
      rsp_mesi         <= MesiI;
      rsp_multi_hit    <= 1'b0;
      rsp_victim       <= '0;
      rsp_victim_dirty <= 1'b0;
    end else if (xfer) begin
      rsp_valid        <= 1'b1;
      rsp_hit          <= hit_c;
      rsp_read_hit     <= hit_c && !req_write;
      rsp_write_hit    <= hit_c && req_write;
      rsp_way          <= way_c;
      rsp_mesi         <= mesi_c;
      rsp_multi_hit    <= multi_c;
      rsp_victim       <= victim_c;
      rsp_victim_dirty <= dirty_c;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef CACHE_LOOKUP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstb || stats_clr) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      multi_cnt <= '0;
    end else if (xfer) begin
      if (hit_c) begin
        if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      end else begin
        if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      end
      if (multi_c && (multi_cnt != '1)) multi_cnt <= multi_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Self-checking bench for cache_tag_lookup (WAYS=8, TAG=12): directed literal checks plus a
// randomized phase compared every cycle against a behavioural model.
module tb_cache_tag_lookup;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] tag_in = '0;
  logic [95:0] set_tags = '0;
  logic [15:0] set_mesi = '0;
  logic [6:0]  set_plru = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit, rsp_read_hit, rsp_write_hit, rsp_multi_hit, rsp_victim_dirty;
  logic [2:0]  rsp_way, rsp_victim;
  logic [1:0]  rsp_mesi;
`ifdef CACHE_LOOKUP_STATS_EN
  logic        stats_clr = 1'b0;
  logic [3:0]  hit_cnt, miss_cnt, multi_cnt;
`endif

  cache_tag_lookup #(
    .WAYS(8),
    .TAG (12)
`ifdef CACHE_LOOKUP_STATS_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk             (clk),
    .rstb            (rstb),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .tag_in          (tag_in),
    .set_tags        (set_tags),
    .set_mesi        (set_mesi),
    .set_plru        (set_plru),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_hit         (rsp_hit),
    .rsp_read_hit    (rsp_read_hit),
    .rsp_write_hit   (rsp_write_hit),
    .rsp_way         (rsp_way),
    .rsp_mesi        (rsp_mesi),
    .rsp_multi_hit   (rsp_multi_hit),
    .rsp_victim      (rsp_victim),
    .rsp_victim_dirty(rsp_victim_dirty)
`ifdef CACHE_LOOKUP_STATS_EN
    ,
    .stats_clr       (stats_clr),
    .hit_cnt         (hit_cnt),
    .miss_cnt        (miss_cnt),
    .multi_cnt       (multi_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       hit;
    logic       rd_hit;
    logic       wr_hit;
    logic [2:0] way;
    logic [1:0] mesi;
    logic       multi;
    logic [2:0] victim;
    logic       dirty;
  } rsp_t;

  // Reference: counts matches, takes the first invalid way, else walks the heap-ordered tree.
  function automatic rsp_t model(input logic [95:0] tg, input logic [15:0] ms,
                                 input logic [6:0] pl, input logic [11:0] t, input logic wr);
    rsp_t r;
    int   n     = 0;
    int   first = -1;
    int   inv   = -1;
    int   node  = 0;
    int   vic;
    for (int w = 0; w < 8; w++) begin
      if (tg[w*12 +: 12] == t && ms[w*2 +: 2] != 2'b00) begin
        n++;
        if (first < 0) first = w;
      end
      if (ms[w*2 +: 2] == 2'b00 && inv < 0) inv = w;
    end
    r.hit    = (n > 0);
    r.rd_hit = (n > 0) && !wr;
    r.wr_hit = (n > 0) && wr;
    r.way    = (first < 0) ? 3'd0 : 3'(first);
    r.mesi   = (first < 0) ? 2'b00 : ms[first*2 +: 2];
    r.multi  = (n > 1);
    if (inv >= 0) begin
      vic = inv;
    end else begin
      for (int l = 0; l < 3; l++) node = 2 * node + 1 + int'(pl[node]);
      vic = node - 7;
    end
    r.victim = 3'(vic);
    r.dirty  = (ms[vic*2 +: 2] == 2'b11);
    return r;
  endfunction

  rsp_t dut_r;
  assign dut_r = {rsp_hit, rsp_read_hit, rsp_write_hit, rsp_way, rsp_mesi, rsp_multi_hit,
                  rsp_victim, rsp_victim_dirty};

  logic mon_en    = 1'b0;
  logic exp_v     = 1'b0;
  logic exp_known = 1'b1;
  rsp_t exp_r     = '0;

  // Compare mid-cycle, then advance the model to what the next rising edge must produce.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      chk("req_ready", 32'(req_ready), 32'(!exp_v || rsp_ready));
      if (exp_known) chk("rsp_fields", 32'(dut_r), 32'(exp_r));
      if (!rstb) begin
        exp_v     = 1'b0;
        exp_r     = '0;
        exp_known = 1'b1;
      end else if (req_valid && (!exp_v || rsp_ready)) begin
        exp_r     = model(set_tags, set_mesi, set_plru, tag_in, req_write);
        exp_v     = 1'b1;
        exp_known = 1'b1;
      end else if (rsp_ready && exp_v) begin
        exp_v     = 1'b0;
        exp_known = 1'b0;
      end
    end
  end

  logic [95:0] base_tags;
  logic [15:0] all_e;

  task automatic send(input logic [95:0] tg, input logic [15:0] ms, input logic [6:0] pl,
                      input logic [11:0] t, input logic wr);
    set_tags  = tg;
    set_mesi  = ms;
    set_plru  = pl;
    tag_in    = t;
    req_write = wr;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [95:0] tg;
    logic [15:0] ms;
    for (int w = 0; w < 8; w++) base_tags[w*12 +: 12] = 12'(12'h100 + w);
    all_e = {8{2'b10}};

    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_fields", 32'(dut_r), 32'd0);
    rstb = 1'b1;

    // Single hit in way 5.
    tg = base_tags;
    tg[5*12 +: 12] = 12'h3A5;
    send(tg, all_e, 7'd0, 12'h3A5, 1'b0);
    chk("hit5_valid", 32'(rsp_valid), 32'd1);
    chk("hit5_hit", 32'(rsp_hit), 32'd1);
    chk("hit5_rdhit", 32'(rsp_read_hit), 32'd1);
    chk("hit5_wrhit", 32'(rsp_write_hit), 32'd0);
    chk("hit5_way", 32'(rsp_way), 32'd5);
    chk("hit5_mesi", 32'(rsp_mesi), 32'd2);
    chk("hit5_multi", 32'(rsp_multi_hit), 32'd0);

    // Same tag in ways 2 and 6, both S.
    tg = base_tags;
    tg[2*12 +: 12] = 12'h0AB;
    tg[6*12 +: 12] = 12'h0AB;
    send(tg, {8{2'b01}}, 7'd0, 12'h0AB, 1'b1);
    chk("multi_way", 32'(rsp_way), 32'd2);
    chk("multi_flag", 32'(rsp_multi_hit), 32'd1);
    chk("multi_wrhit", 32'(rsp_write_hit), 32'd1);

    // Matching tag but way invalid.
    tg = base_tags;
    tg[2*12 +: 12] = 12'h0AB;
    ms = all_e;
    ms[2*2 +: 2] = 2'b00;
    send(tg, ms, 7'd0, 12'h0AB, 1'b0);
    chk("inv_hit", 32'(rsp_hit), 32'd0);
    chk("inv_way", 32'(rsp_way), 32'd0);
    chk("inv_mesi", 32'(rsp_mesi), 32'd0);
    chk("inv_victim", 32'(rsp_victim), 32'd2);

    // Victim selection.
    ms = all_e;
    ms[3*2 +: 2] = 2'b00;
    ms[4*2 +: 2] = 2'b00;
    send(base_tags, ms, 7'h7F, 12'hFFF, 1'b0);
    chk("vic_first_inv", 32'(rsp_victim), 32'd3);
    send(base_tags, all_e, 7'd0, 12'hFFF, 1'b0);
    chk("vic_plru0", 32'(rsp_victim), 32'd0);
    chk("vic_plru0_dirty", 32'(rsp_victim_dirty), 32'd0);
    ms = all_e;
    ms[7*2 +: 2] = 2'b11;
    send(base_tags, ms, 7'b1000101, 12'hFFF, 1'b0);
    chk("vic_plru7", 32'(rsp_victim), 32'd7);
    chk("vic_plru7_dirty", 32'(rsp_victim_dirty), 32'd1);

    // Backpressure, then a back-to-back stream of four.
    idle();
    rsp_ready = 1'b0;
    send(base_tags, all_e, 7'd0, 12'h106, 1'b0);
    set_tags  = base_tags;
    set_mesi  = all_e;
    tag_in    = 12'h101;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_way", 32'(rsp_way), 32'd6);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tag_in = 12'(12'h100 + i);
      @(posedge clk);
      #1;
      chk("stream_valid", 32'(rsp_valid), 32'd1);
      chk("stream_way", 32'(rsp_way), 32'(i));
    end
    req_valid = 1'b0;

    // Reset while a response is stalled; a request during reset is dropped.
    idle();
    rsp_ready = 1'b0;
    send(base_tags, all_e, 7'h7F, 12'h105, 1'b0);
    rstb = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_fields", 32'(dut_r), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_req_dropped", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    rstb = 1'b1;
    rsp_ready = 1'b1;
    send(base_tags, all_e, 7'd0, 12'h103, 1'b0);
    chk("post_rst_valid", 32'(rsp_valid), 32'd1);
    chk("post_rst_way", 32'(rsp_way), 32'd3);
    chk("post_rst_hit", 32'(rsp_hit), 32'd1);

`ifdef CACHE_LOOKUP_STATS_EN
    idle();
    stats_clr = 1'b1;
    idle();
    stats_clr = 1'b0;
    for (int i = 0; i < 20; i++) send(base_tags, all_e, 7'd0, 12'h101, 1'b0);
    chk("stats_hit_sat", 32'(hit_cnt), 32'd15);
    for (int i = 0; i < 3; i++) send(base_tags, all_e, 7'd0, 12'hFFF, 1'b0);
    chk("stats_miss3", 32'(miss_cnt), 32'd3);
    stats_clr = 1'b1;
    send(base_tags, all_e, 7'd0, 12'hFFF, 1'b0);
    stats_clr = 1'b0;
    chk("stats_clr_miss", 32'(miss_cnt), 32'd0);
    chk("stats_clr_hit", 32'(hit_cnt), 32'd0);
`endif

    // Randomized traffic drawn from a small tag pool to provoke hits and multi-hits.
    for (int c = 0; c < 500; c++) begin
      rstb      = ($urandom_range(63) != 0);
      req_valid = 1'(($urandom_range(3) != 0));
      rsp_ready = 1'(($urandom_range(3) != 0));
      req_write = 1'($urandom_range(1));
      for (int w = 0; w < 8; w++) begin
        set_tags[w*12 +: 12] = 12'(12'h200 + $urandom_range(3));
        set_mesi[w*2 +: 2]   = ($urandom_range(3) == 0) ? 2'(0) : 2'($urandom_range(3));
      end
      set_plru = 7'($urandom);
      tag_in   = 12'(12'h200 + $urandom_range(4));
      @(posedge clk);
      #1;
    end
    rstb = 1'b1;
    idle();
    idle();
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
